// File: rtl/regport_pkg.sv
// Shared types and defaults for the register-file read-port arbiter.
package regport_pkg;

    localparam int unsigned NREQ_DEF   = 4;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2
    } state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  winner,
    output logic             valid
);

    logic [IDX_W-1:0] pos;

    // Scan last+1 .. last+NREQ; the final offset revisits last itself.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        pos    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            pos = IDX_W'((32'(last) + k) % NREQ);
            if (!valid && req[pos]) begin
                winner[pos] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regport_arbiter.sv
// Round-robin arbiter sharing the register file's single read-mux port;
// one access in flight, CAP doubles as the next arbitration cycle.
module regport_arbiter
    import regport_pkg::*;
#(
    parameter int unsigned NREQ   = NREQ_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    output logic [NREQ-1:0]          gnt,
    output logic [ADDR_W-1:0]        rd_sel,
    input  logic [DATA_W-1:0]        rd_data,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy
);

    localparam int unsigned IDX_W = idx_width(NREQ);

    state_e             state;
    state_e             state_nxt;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   win;

    logic [NREQ-1:0]    pick_onehot;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [ADDR_W-1:0]  pick_addr;

    logic               arb_fire;
    logic               capture;
    logic [NREQ-1:0]    gnt_nxt;
    logic [NREQ-1:0]    rsp_valid_nxt;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .last   (last),
        .winner (pick_onehot),
        .valid  (pick_valid)
    );

    // Winner one-hot to index, and that requester's register index.
    always_comb begin
        pick_idx  = '0;
        pick_addr = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) begin
                pick_idx  = IDX_W'(i);
                pick_addr = addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, CAP: state_nxt = pick_valid ? RD : IDLE;
            RD:        state_nxt = CAP;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output/datapath control decoded from the current state.
    always_comb begin
        arb_fire      = 1'b0;
        capture       = 1'b0;
        gnt_nxt       = '0;
        rsp_valid_nxt = '0;
        case (state)
            IDLE, CAP: begin
                arb_fire = pick_valid;
                gnt_nxt  = pick_onehot;
            end
            RD: begin
                capture       = 1'b1;
                rsp_valid_nxt = NREQ'(1) << win;
            end
            default: begin
                arb_fire = 1'b0;
            end
        endcase
    end

    // Pointers and registered outputs; rd_sel holds the last index between accesses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last      <= IDX_W'(NREQ - 1);
            win       <= '0;
            gnt       <= '0;
            rd_sel    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            gnt       <= gnt_nxt;
            rsp_valid <= rsp_valid_nxt;
            busy      <= (state_nxt != IDLE);
            if (arb_fire) begin
                last   <= pick_idx;
                win    <= pick_idx;
                rd_sel <= pick_addr;
            end
            if (capture) begin
                rsp_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_regport_arbiter.sv
// Directed and randomized checks of regport_arbiter against a transaction-level model.
module tb_regport_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    logic                   clk;
    logic                   reset_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ-1:0]        gnt;
    logic [ADDR_W-1:0]      rd_sel;
    logic [DATA_W-1:0]      rd_data;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic                   busy;

    logic [DATA_W-1:0] regs [32];
    int total;
    int bad;

    regport_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .addr      (addr),
        .gnt       (gnt),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    assign rd_data = regs[rd_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_reset();
        req     = '0;
        addr    = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Model state for the randomized phase.
    int          m_phase;   // 0 idle, 1 read in flight, 2 capture
    int          m_last;
    int          m_win;
    int          w;
    logic [3:0]  e_gnt;
    logic [3:0]  e_rv;
    logic [4:0]  e_sel;
    logic [31:0] e_data;
    logic        e_busy;

    initial begin
        total = 0;
        bad   = 0;
        for (int j = 0; j < 32; j++) regs[j] = 32'hC0DE_0000 | 32'(j);
        regs[7] = 32'h0000_00A5;
        do_reset();

        // Reset values
        chk("rst_gnt",   64'(gnt),       64'(0));
        chk("rst_rv",    64'(rsp_valid), 64'(0));
        chk("rst_sel",   64'(rd_sel),    64'(0));
        chk("rst_data",  64'(rsp_data),  64'(0));
        chk("rst_busy",  64'(busy),      64'(0));

        // Single request to r7
        req = 4'b0001;
        set_addr(0, 5'd7);
        step();
        chk("s_gnt",  64'(gnt),    64'(4'b0001));
        chk("s_sel",  64'(rd_sel), 64'(7));
        chk("s_busy1", 64'(busy),  64'(1));
        req = 4'b0000;
        step();
        chk("s_gnt0", 64'(gnt),       64'(0));
        chk("s_rv",   64'(rsp_valid), 64'(4'b0001));
        chk("s_data", 64'(rsp_data),  64'(32'h0000_00A5));
        chk("s_busy2", 64'(busy),     64'(1));
        step();
        chk("s_idle", 64'(busy),      64'(0));
        chk("s_rv0",  64'(rsp_valid), 64'(0));
        chk("s_hold", 64'(rd_sel),    64'(7));

        // Four continuous requesters: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i, 5'(10 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_gnt", 64'(gnt),    64'(4'b0001 << (k % 4)));
            chk("rr_sel", 64'(rd_sel), 64'(10 + (k % 4)));
            step();
            chk("rr_gap",  64'(gnt),       64'(0));
            chk("rr_rv",   64'(rsp_valid), 64'(4'b0001 << (k % 4)));
            chk("rr_data", 64'(rsp_data),  64'(regs[10 + (k % 4)]));
        end
        req = '0;
        step();

        // Rotation: last=0, req=0101 -> 2 then 0
        do_reset();
        req = 4'b0001;
        set_addr(0, 5'd1);
        set_addr(2, 5'd2);
        step();
        req = 4'b0000;
        step();
        step();
        req = 4'b0101;
        step();
        chk("rot_w2", 64'(gnt), 64'(4'b0100));
        step();
        step();
        chk("rot_w0", 64'(gnt), 64'(4'b0001));
        req = '0;
        step();
        step();

        // Back-to-back from requester 0: r3 then r4
        do_reset();
        req = 4'b0001;
        set_addr(0, 5'd3);
        step();
        chk("b2b_sel1", 64'(rd_sel), 64'(3));
        set_addr(0, 5'd4);
        step();
        chk("b2b_d1", 64'(rsp_data),  64'(regs[3]));
        chk("b2b_v1", 64'(rsp_valid), 64'(4'b0001));
        step();
        chk("b2b_g2",   64'(gnt),    64'(4'b0001));
        chk("b2b_sel2", 64'(rd_sel), 64'(4));
        req = '0;
        step();
        chk("b2b_d2", 64'(rsp_data),  64'(regs[4]));
        chk("b2b_v2", 64'(rsp_valid), 64'(4'b0001));
        step();

        // Reset asserted during RD abandons the access
        do_reset();
        req = 4'b0001;
        set_addr(0, 5'd5);
        step();
        chk("mr_gnt", 64'(gnt), 64'(4'b0001));
        reset_n = 1'b0;
        req = '0;
        #3;
        chk("mr_rv",   64'(rsp_valid), 64'(0));
        chk("mr_data", 64'(rsp_data),  64'(0));
        chk("mr_busy", 64'(busy),      64'(0));
        #2;
        reset_n = 1'b1;
        step();
        chk("mr_rv2",   64'(rsp_valid), 64'(0));
        chk("mr_data2", 64'(rsp_data),  64'(0));
        req = 4'b1000;
        set_addr(3, 5'd9);
        step();
        chk("mr_g3",  64'(gnt),    64'(4'b1000));
        chk("mr_sel", 64'(rd_sel), 64'(9));
        req = '0;
        step();
        chk("mr_v3", 64'(rsp_valid), 64'(4'b1000));
        chk("mr_d3", 64'(rsp_data),  64'(regs[9]));
        step();

        // Request arriving during RD is granted at the CAP edge
        do_reset();
        req = 4'b0001;
        set_addr(0, 5'd1);
        step();
        req = 4'b0100;
        set_addr(2, 5'd2);
        step();
        chk("rd_v0",   64'(rsp_valid), 64'(4'b0001));
        chk("rd_d0",   64'(rsp_data),  64'(regs[1]));
        step();
        chk("rd_g2",   64'(gnt),       64'(4'b0100));
        chk("rd_hold", 64'(rsp_data),  64'(regs[1]));
        req = '0;
        step();
        chk("rd_v2", 64'(rsp_valid), 64'(4'b0100));
        chk("rd_d2", 64'(rsp_data),  64'(regs[2]));
        step();

        // Randomized traffic against the model
        do_reset();
        m_phase = 0;
        m_last  = NREQ - 1;
        m_win   = 0;
        e_sel   = '0;
        e_data  = '0;
        for (int c = 0; c < 600; c++) begin
            req = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) set_addr(i, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 31)] = $urandom;
            e_gnt = '0;
            e_rv  = '0;
            if (m_phase == 1) begin
                e_rv    = 4'b0001 << m_win;
                e_data  = regs[e_sel];
                m_phase = 2;
            end else if (req != 0) begin
                w = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (w < 0 && req[(m_last + k) % 4]) w = (m_last + k) % 4;
                end
                e_gnt   = 4'b0001 << w;
                e_sel   = addr[w*ADDR_W +: ADDR_W];
                m_last  = w;
                m_win   = w;
                m_phase = 1;
            end else begin
                m_phase = 0;
            end
            e_busy = (m_phase != 0);
            step();
            chk("rnd_gnt",  64'(gnt),       64'(e_gnt));
            chk("rnd_rv",   64'(rsp_valid), 64'(e_rv));
            chk("rnd_sel",  64'(rd_sel),    64'(e_sel));
            chk("rnd_data", 64'(rsp_data),  64'(e_data));
            chk("rnd_busy", 64'(busy),      64'(e_busy));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
